// File: rtl/param_universal_shift_register_pkg.sv
// Shared definitions for the universal shift register slice.
// Contents:
//   op_t / OP_*   : 3-bit operation encodings.
//   state_e       : burst FSM states (IDLE, BURST).
//   is_shift_op() : true for SHL/SHR/ROL/ROR/ASR.
//                   These are the ops that move a bit out and can be burst.
package usr_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_HOLD = 3'b000;
  localparam op_t OP_SHL  = 3'b001;
  localparam op_t OP_SHR  = 3'b010;
  localparam op_t OP_LOAD = 3'b011;
  localparam op_t OP_ROL  = 3'b100;
  localparam op_t OP_ROR  = 3'b101;
  localparam op_t OP_ASR  = 3'b110;
  localparam op_t OP_CLR  = 3'b111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic logic is_shift_op(input op_t op);
    logic res;
    case (op)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: res = 1'b1;
      default:                                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/param_universal_shift_register_if.sv
// Bus interface of the universal shift register.
// Modport roles:
//   master : drives op/data_in/serial_in/start/count.
//            Observes data_out/serial_out/busy/done.
//   slave  : the register itself, with the opposite directions.
interface usr_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  import usr_pkg::*;

  op_t              op;
  logic [WIDTH-1:0] data_in;
  logic             serial_in;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output op, data_in, serial_in, start, count,
    input  data_out, serial_out, busy, done
  );

  modport slave (
    input  op, data_in, serial_in, start, count,
    output data_out, serial_out, busy, done
  );
endinterface

// File: rtl/param_universal_shift_register_shift_step.sv
// Combinational single-step operator for the universal shift register.
// Ports:
//   q           : current register value.
//   op          : operation to apply.
//   serial_in   : fill bit for SHL/SHR.
//   data_in     : value used by LOAD.
//   next_q      : register value after the operation.
//   shift_bit   : bit pushed out by a shift/rotate.
//   shift_valid : high when op moves a bit out, i.e. serial_out should update.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_t              op,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] next_q,
  output logic             shift_bit,
  output logic             shift_valid
);

  // Next-value mux and outgoing bit for every operation
  always_comb begin
    next_q      = q;
    shift_bit   = 1'b0;
    shift_valid = is_shift_op(op);
    case (op)
      OP_HOLD: next_q = q;
      OP_SHL: begin
        next_q    = {q[WIDTH-2:0], serial_in};
        shift_bit = q[WIDTH-1];
      end
      OP_SHR: begin
        next_q    = {serial_in, q[WIDTH-1:1]};
        shift_bit = q[0];
      end
      OP_LOAD: next_q = data_in;
      OP_ROL: begin
        next_q    = {q[WIDTH-2:0], q[WIDTH-1]};
        shift_bit = q[WIDTH-1];
      end
      OP_ROR: begin
        next_q    = {q[0], q[WIDTH-1:1]};
        shift_bit = q[0];
      end
      OP_ASR: begin
        next_q    = {q[WIDTH-1], q[WIDTH-1:1]};
        shift_bit = q[0];
      end
      OP_CLR:  next_q = {WIDTH{1'b0}};
      default: next_q = q;
    endcase
  end

endmodule

// File: rtl/param_universal_shift_register.sv
// Parametrised universal shift register with a counted burst engine.
// Ports:
//   clk   : clock, rising edge.
//   reset : asynchronous, active-high reset.
//   bus   : usr_if.slave.
//     op, data_in, serial_in, start, count : inputs.
//     data_out, serial_out, busy, done     : registered outputs.
// In IDLE one op is applied per clock.
// start with a shift op and count>=2 performs the first shift immediately.
// It then runs the remaining count-1 shifts in BURST, ignoring bus inputs
// other than serial_in.
module param_universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic  clk,
  input logic  reset,
  usr_if.slave bus
);

  logic [WIDTH-1:0] q_r;
  logic             serial_out_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] remaining_r;
  op_t              op_q_r;
  state_e           state_r;

  op_t              eff_op_s;
  logic             apply_s;
  logic             burst_req_s;
  logic [WIDTH-1:0] next_q_s;
  logic             shift_bit_s;
  logic             shift_valid_s;

  // Operation select: latched op during a burst, live op otherwise.
  // A zero-length burst request leaves the data untouched.
  always_comb begin
    burst_req_s = bus.start && is_shift_op(bus.op);
    if (state_r == BURST) begin
      eff_op_s = op_q_r;
      apply_s  = 1'b1;
    end else begin
      eff_op_s = bus.op;
      apply_s  = !(burst_req_s && (bus.count == {CNT_W{1'b0}}));
    end
  end

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .q           (q_r),
    .op          (eff_op_s),
    .serial_in   (bus.serial_in),
    .data_in     (bus.data_in),
    .next_q      (next_q_s),
    .shift_bit   (shift_bit_s),
    .shift_valid (shift_valid_s)
  );

  // Data register and serial-out tap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r          <= {WIDTH{1'b0}};
      serial_out_r <= 1'b0;
    end else if (apply_s) begin
      q_r <= next_q_s;
      if (shift_valid_s) begin
        serial_out_r <= shift_bit_s;
      end else begin
        serial_out_r <= serial_out_r;
      end
    end else begin
      q_r          <= q_r;
      serial_out_r <= serial_out_r;
    end
  end

  // Burst FSM, remaining-shift counter and busy/done flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      remaining_r <= {CNT_W{1'b0}};
      op_q_r      <= OP_HOLD;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (burst_req_s) begin
            if (bus.count > CNT_W'(1)) begin
              // First shift happens on this edge; count-1 remain
              op_q_r      <= bus.op;
              remaining_r <= bus.count - CNT_W'(1);
              busy_r      <= 1'b1;
              state_r     <= BURST;
            end else begin
              // count of 0 or 1 completes on this edge
              done_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BURST: begin
          remaining_r <= remaining_r - CNT_W'(1);
          if (remaining_r == CNT_W'(1)) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else begin
            state_r <= BURST;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = q_r;
  assign bus.serial_out = serial_out_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Self-checking bench for param_universal_shift_register (WIDTH=8, CNT_W=4).
// Stimulus:
//   - a table of single-step vectors;
//   - hand-written burst, lockout, back-to-back and async-reset sequences.
module tb_param_universal_shift_register;
  import usr_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  usr_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  param_universal_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    op_t        op;
    logic [7:0] din;
    logic       si;
    logic [7:0] exp_q;
    logic       exp_so;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Set inputs at the falling edge, then advance past the next rising edge.
  task automatic drive(input op_t op, input logic [7:0] din, input logic si,
                       input logic st, input logic [3:0] cnt);
    @(negedge clk);
    bus.op        = op;
    bus.data_in   = din;
    bus.serial_in = si;
    bus.start     = st;
    bus.count     = cnt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    logic [7:0] exp_burst[4];
    logic [7:0] exp_b2b[2];

    n_total = 0;
    n_pass  = 0;

    vecs[0]  = '{OP_LOAD, 8'h90, 1'b0, 8'h90, 1'b0};
    vecs[1]  = '{OP_ASR,  8'h00, 1'b0, 8'hC8, 1'b0};
    vecs[2]  = '{OP_ASR,  8'h00, 1'b0, 8'hE4, 1'b0};
    vecs[3]  = '{OP_LOAD, 8'h01, 1'b0, 8'h01, 1'b0};
    vecs[4]  = '{OP_ROR,  8'h00, 1'b0, 8'h80, 1'b1};
    vecs[5]  = '{OP_LOAD, 8'h40, 1'b0, 8'h40, 1'b1};
    vecs[6]  = '{OP_ROR,  8'h00, 1'b0, 8'h20, 1'b0};
    vecs[7]  = '{OP_LOAD, 8'h80, 1'b0, 8'h80, 1'b0};
    vecs[8]  = '{OP_ROL,  8'h00, 1'b0, 8'h01, 1'b1};
    vecs[9]  = '{OP_CLR,  8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[10] = '{OP_LOAD, 8'hA5, 1'b0, 8'hA5, 1'b1};
    vecs[11] = '{OP_SHL,  8'h00, 1'b0, 8'h4A, 1'b1};
    vecs[12] = '{OP_SHR,  8'h00, 1'b1, 8'hA5, 1'b0};
    vecs[13] = '{OP_HOLD, 8'h3C, 1'b1, 8'hA5, 1'b0};

    bus.op        = OP_HOLD;
    bus.data_in   = 8'h00;
    bus.serial_in = 1'b0;
    bus.start     = 1'b0;
    bus.count     = 4'd0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q",    {24'd0, bus.data_out}, 32'h00);
    chk("reset_so",   {31'd0, bus.serial_out}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single-step table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].din, vecs[i].si, 1'b0, 4'd0);
      chk($sformatf("vec%0d_q", i),    {24'd0, bus.data_out}, {24'd0, vecs[i].exp_q});
      chk($sformatf("vec%0d_so", i),   {31'd0, bus.serial_out}, {31'd0, vecs[i].exp_so});
      chk($sformatf("vec%0d_busy", i), {31'd0, bus.busy}, 32'd0);
    end

    // LOAD 0x81, then SHL burst of 3 with serial_in=1
    drive(OP_LOAD, 8'h81, 1'b1, 1'b0, 4'd0);
    drive(OP_SHL, 8'h00, 1'b1, 1'b1, 4'd3);
    chk("b3_e1_q",  {24'd0, bus.data_out}, 32'h03);
    chk("b3_e1_so", {31'd0, bus.serial_out}, 32'd1);
    busy_cnt = bus.busy ? 1 : 0;
    done_cnt = bus.done ? 1 : 0;
    drive(OP_HOLD, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("b3_e2_q",  {24'd0, bus.data_out}, 32'h07);
    chk("b3_e2_so", {31'd0, bus.serial_out}, 32'd0);
    busy_cnt += bus.busy ? 1 : 0;
    done_cnt += bus.done ? 1 : 0;
    drive(OP_HOLD, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("b3_e3_q",    {24'd0, bus.data_out}, 32'h0F);
    chk("b3_e3_so",   {31'd0, bus.serial_out}, 32'd0);
    chk("b3_e3_done", {31'd0, bus.done}, 32'd1);
    busy_cnt += bus.busy ? 1 : 0;
    drive(OP_HOLD, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("b3_done_after", {31'd0, bus.done}, 32'd0);
    chk("b3_busy_cycles", busy_cnt, 32'd2);
    chk("b3_early_done",  done_cnt, 32'd0);

    // count=0: no data change, done next cycle, never busy
    drive(OP_LOAD, 8'h5A, 1'b0, 1'b0, 4'd0);
    drive(OP_SHL, 8'h00, 1'b1, 1'b1, 4'd0);
    chk("c0_q",    {24'd0, bus.data_out}, 32'h5A);
    chk("c0_done", {31'd0, bus.done}, 32'd1);
    chk("c0_busy", {31'd0, bus.busy}, 32'd0);

    // count=1: single shift, done next cycle, stay idle
    drive(OP_SHR, 8'h00, 1'b0, 1'b1, 4'd1);
    chk("c1_q",    {24'd0, bus.data_out}, 32'h2D);
    chk("c1_done", {31'd0, bus.done}, 32'd1);
    chk("c1_busy", {31'd0, bus.busy}, 32'd0);

    // start with LOAD is a plain load, no done
    drive(OP_LOAD, 8'h3C, 1'b0, 1'b1, 4'd5);
    chk("sl_q",    {24'd0, bus.data_out}, 32'h3C);
    chk("sl_done", {31'd0, bus.done}, 32'd0);
    chk("sl_busy", {31'd0, bus.busy}, 32'd0);

    // Busy lockout: ROR x4 on 0x0F while inputs request LOAD 0xAA
    exp_burst[0] = 8'h87;
    exp_burst[1] = 8'hC3;
    exp_burst[2] = 8'hE1;
    exp_burst[3] = 8'hF0;
    drive(OP_LOAD, 8'h0F, 1'b0, 1'b0, 4'd0);
    done_cnt = 0;
    drive(OP_ROR, 8'h00, 1'b0, 1'b1, 4'd4);
    chk("lk_e0_q", {24'd0, bus.data_out}, {24'd0, exp_burst[0]});
    chk("lk_e0_busy", {31'd0, bus.busy}, 32'd1);
    done_cnt += bus.done ? 1 : 0;
    for (int e = 1; e < 4; e++) begin
      drive(OP_LOAD, 8'hAA, 1'b0, 1'b1, 4'd9);
      chk($sformatf("lk_e%0d_q", e), {24'd0, bus.data_out}, {24'd0, exp_burst[e]});
      done_cnt += bus.done ? 1 : 0;
    end
    chk("lk_done_once", done_cnt, 32'd1);
    chk("lk_busy_end",  {31'd0, bus.busy}, 32'd0);

    // Back-to-back: SHR x2 requested in the done cycle
    exp_b2b[0] = 8'h78;
    exp_b2b[1] = 8'h3C;
    drive(OP_SHR, 8'h00, 1'b0, 1'b1, 4'd2);
    chk("bb_e0_q",    {24'd0, bus.data_out}, {24'd0, exp_b2b[0]});
    chk("bb_e0_busy", {31'd0, bus.busy}, 32'd1);
    chk("bb_e0_done", {31'd0, bus.done}, 32'd0);
    drive(OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
    chk("bb_e1_q",    {24'd0, bus.data_out}, {24'd0, exp_b2b[1]});
    chk("bb_e1_done", {31'd0, bus.done}, 32'd1);
    drive(OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
    chk("bb_done_clear", {31'd0, bus.done}, 32'd0);

    // Reset mid-burst: SHL x7 on 0xFF, async reset in cycle 3
    drive(OP_LOAD, 8'hFF, 1'b1, 1'b0, 4'd0);
    drive(OP_SHL, 8'h00, 1'b1, 1'b1, 4'd7);
    drive(OP_HOLD, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("rm_busy_pre", {31'd0, bus.busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rm_q",    {24'd0, bus.data_out}, 32'h00);
    chk("rm_busy", {31'd0, bus.busy}, 32'd0);
    chk("rm_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      drive(OP_HOLD, 8'h00, 1'b1, 1'b0, 4'd0);
      done_cnt += bus.done ? 1 : 0;
      busy_cnt += bus.busy ? 1 : 0;
    end
    chk("rm_no_done", done_cnt, 32'd0);
    chk("rm_no_busy", busy_cnt, 32'd0);
    chk("rm_q_after", {24'd0, bus.data_out}, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
